counter_ctrl_arb: RTL and testbench
===================================

// Module: counter_ctrl_arb
// PURPOSE
//  Sequences and shares one WIDTH-bit up-counter register between NUM_REQ requesters.
//  Each requester issues a command (CLEAR, LOAD, STEP n, QUERY) over a valid/ready port.
//  A round-robin arbiter grants one command at a time. A small FSM executes it on the
//  counter and returns a one-cycle completion pulse.
//  Sits between the control agents and the counter datapath; it is the only writer of it.
// PARAMETERS
//  NUM_REQ  4  number of requester ports (>=2)
//  WIDTH    8  counter / argument width in bits
// PORTS
//  clk        in   1                clock, all logic on posedge
//  rst        in   1                reset, synchronous, active-high
//  req_valid  in   NUM_REQ          per-requester command valid
//  req_ready  out  NUM_REQ          per-requester accept, at most one bit high
//  req_op     in   2*NUM_REQ        per-requester op, slice i = [2*i+:2]
//  req_arg    in   WIDTH*NUM_REQ    per-requester argument, slice i = [WIDTH*i+:WIDTH]
//  cnt_value  out  WIDTH            current counter value
//  busy       out  1                high whenever FSM not IDLE
//  done_valid out  1                one-cycle completion pulse
//  done_id    out  $clog2(NUM_REQ)  requester index of completed command
//  done_value out  WIDTH            cnt_value after the completed command
// BEHAVIOUR
//  Ops: 00 CLEAR (cnt=0); 01 LOAD (cnt=arg); 10 STEP (cnt+=1, repeated arg times); 11 QUERY (no change).
//  Reset: cnt_value=0, state=IDLE, rr pointer=0, busy=0, done_valid=0, done_id=0, done_value=0.
//  In reset cycle req_ready=0.
//  Handshake: a requester holds valid, op and arg stable until it sees ready.
//  Transfer happens on the edge where valid&ready. req_ready is combinational.
//  req_ready is non-zero only in IDLE. It is one-hot to the grantee.
//  Arbitration: round-robin, searching from ptr upward with wrap to 0.
//  On grant to i, ptr <= (i+1) mod NUM_REQ. ptr is unchanged when no grant.
//  FSM: IDLE -> EXEC on grant. On that grant edge, latch op, arg, id, and STEP remaining=arg.
//  EXEC, CLEAR/LOAD/QUERY: update cnt at end of the first EXEC cycle, then -> DONE.
//  EXEC, STEP: if remaining==0 -> DONE with no increment.
//  EXEC, STEP, otherwise: cnt+=1 and remaining-=1 each cycle.
//  EXEC, STEP, last increment: -> DONE on the same edge.
//  DONE: done_valid=1 for exactly this cycle, with done_id and done_value=cnt_value. Then -> IDLE.
//  No new grant is issued during DONE.
//  Timing, accept at edge t, LOAD/CLEAR: cnt_value updates at edge t+1, done_valid high in cycle t+1..t+2.
//  More precisely, done_valid is high between edges t+1 and t+2.
//  Timing, STEP n>0: increments at edges t+1..t+n; done_valid high between edges t+n and t+n+1.
//  Timing, STEP 0: done_valid high between edges t+1 and t+2.
//  Throughput: back-to-back commands, the next grant is possible in the cycle after DONE.
//  Arithmetic: cnt wraps modulo 2^WIDTH (0xFF+1 -> 0x00). No overflow flag.
//  Simultaneous valids: exactly one is granted; the others stay pending with ready=0.
//  A requester that drops valid before grant is simply not considered.
//  Reset mid-operation: the command is abandoned, no done pulse, and all state returns to reset values.
//  cnt_value changes only in EXEC. busy=1 in EXEC and DONE.
// STRUCTURE
//  Package counter_ctrl_pkg: op_e enum (OP_CLEAR, OP_LOAD, OP_STEP, OP_QUERY), and
//  state_e enum (S_IDLE, S_EXEC, S_DONE).
//  Sub-module rr_arbiter #(N): inputs req[N], en, and ptr update on grant;
//  outputs grant one-hot and grant_idx. The top holds the FSM, latched command and counter.
// TESTING
//  1 Reset held 3 cycles with all valids high -> req_ready=0, cnt_value=0, done_valid=0, busy=0.
//  2 req1 LOAD 0xFE -> ready[1] one cycle; cnt=0xFE next edge; done_valid with id=1, value=0xFE.
//  2 (cont.) Then req2 STEP 3 -> cnt 0xFF,0x00,0x01 on successive edges; done id=2 value=0x01.
//  3 All 4 valid, QUERY, held until ready -> grant order 0,1,2,3.
//  3 (cont.) After re-raising req0 and req3, grant order is 0 then 3 (ptr wrap).
//  4 STEP 0 from req3 -> done one cycle after EXEC, value unchanged; busy high 2 cycles.
//  5 STEP 10 accepted, rst asserted after 4 increments -> cnt=0 next edge, no done pulse, ptr=0, idle.
//  6 CLEAR at cnt=0x55 while req0 waits -> cnt=0, done pulse; req0 ready only after the DONE cycle.

Source files
------------

// File: rtl/counter_ctrl_arb_pkg.sv
// Shared types for the counter command controller: command opcodes and FSM states.
package counter_ctrl_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STEP  = 2'b10,
    OP_QUERY = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/counter_ctrl_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr (wrapping),
// then moves ptr to one past the grantee.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_r;
  logic [N-1:0]  rot_s;
  logic          any_s;
  int            off_s;
  int            idx_s;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    rot_s = N'({req, req} >> ptr_r);
    off_s = 0;
    for (int k = N - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? k : off_s;
    end
    idx_s     = (int'(ptr_r) + off_s >= N) ? (int'(ptr_r) + off_s - N) : (int'(ptr_r) + off_s);
    any_s     = en && (|req);
    grant     = any_s ? (N'(1) << idx_s) : '0;
    grant_idx = any_s ? IW'(idx_s) : '0;
  end

  // Priority pointer advances only when a grant is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if (any_s) begin
      ptr_r <= (grant_idx == IW'(N - 1)) ? '0 : (grant_idx + IW'(1));
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/counter_ctrl_arb.sv
// Shares one up-counter between NUM_REQ command ports; a round-robin grant feeds
// a three-state sequencer that executes the command and pulses done_valid.
module counter_ctrl_arb
  import counter_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_arg,
  output logic [WIDTH-1:0]         cnt_value,
  output logic                     busy,
  output logic                     done_valid,
  output logic [IW-1:0]            done_id,
  output logic [WIDTH-1:0]         done_value
);

  state_e            state_r;
  op_e               op_r;
  logic [WIDTH-1:0]  arg_r;
  logic [WIDTH-1:0]  rem_r;
  logic [IW-1:0]     id_r;
  logic [WIDTH-1:0]  cnt_r;
  logic              busy_r;
  logic              done_valid_r;
  logic [IW-1:0]     done_id_r;
  logic [WIDTH-1:0]  done_value_r;

  logic [NUM_REQ-1:0] grant_s;
  logic [IW-1:0]      grant_idx_s;
  logic               arb_en_s;
  logic [OP_W-1:0]    sel_op_s;
  logic [WIDTH-1:0]   sel_arg_s;
  logic [WIDTH-1:0]   cnt_nxt_s;
  logic               last_s;

  // Grants are only offered while idle, and never during the reset cycle.
  assign arb_en_s = (state_r == S_IDLE) && !rst;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (arb_en_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign req_ready  = grant_s;
  assign cnt_value  = cnt_r;
  assign busy       = busy_r;
  assign done_valid = done_valid_r;
  assign done_id    = done_id_r;
  assign done_value = done_value_r;

  // Select the granted requester's op and argument.
  always_comb begin
    sel_op_s  = '0;
    sel_arg_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_op_s  = grant_s[i] ? req_op[2*i +: 2] : sel_op_s;
      sel_arg_s = grant_s[i] ? req_arg[WIDTH*i +: WIDTH] : sel_arg_s;
    end
  end

  // Counter value after one EXEC cycle, and whether that cycle finishes the command.
  always_comb begin
    cnt_nxt_s = cnt_r;
    last_s    = 1'b1;
    case (op_r)
      OP_CLEAR: cnt_nxt_s = '0;
      OP_LOAD:  cnt_nxt_s = arg_r;
      OP_STEP: begin
        if (rem_r == '0) begin
          cnt_nxt_s = cnt_r;
          last_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + WIDTH'(1);
          last_s    = (rem_r == WIDTH'(1));
        end
      end
      OP_QUERY: cnt_nxt_s = cnt_r;
      default:  cnt_nxt_s = cnt_r;
    endcase
  end

  // Command sequencer: latch on grant, execute, then one DONE cycle before re-arbitrating.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      op_r         <= OP_CLEAR;
      arg_r        <= '0;
      rem_r        <= '0;
      id_r         <= '0;
      cnt_r        <= '0;
      busy_r       <= 1'b0;
      done_valid_r <= 1'b0;
      done_id_r    <= '0;
      done_value_r <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_valid_r <= 1'b0;
          if (|grant_s) begin
            op_r    <= op_e'(sel_op_s);
            arg_r   <= sel_arg_s;
            rem_r   <= sel_arg_s;
            id_r    <= grant_idx_s;
            busy_r  <= 1'b1;
            state_r <= S_EXEC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_EXEC: begin
          cnt_r <= cnt_nxt_s;
          rem_r <= (rem_r == '0) ? '0 : (rem_r - WIDTH'(1));
          if (last_s) begin
            state_r      <= S_DONE;
            done_valid_r <= 1'b1;
            done_id_r    <= id_r;
            done_value_r <= cnt_nxt_s;
          end else begin
            state_r      <= S_EXEC;
          end
        end
        S_DONE: begin
          done_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= S_IDLE;
        end
        default: begin
          done_valid_r <= 1'b0;
          busy_r       <= 1'b0;
          state_r      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_ctrl_arb.sv
// Bench for counter_ctrl_arb: directed scenarios plus random requester traffic,
// all compared each cycle against a command-level model of the shared counter.
module tb_counter_ctrl_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [2*N-1:0]   req_op;
  logic [W*N-1:0]   req_arg;
  logic [W-1:0]     cnt_value;
  logic             busy;
  logic             done_valid;
  logic [1:0]       done_id;
  logic [W-1:0]     done_value;

  always #5 clk = ~clk;

  counter_ctrl_arb #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_arg    (req_arg),
    .cnt_value  (cnt_value),
    .busy       (busy),
    .done_valid (done_valid),
    .done_id    (done_id),
    .done_value (done_value)
  );

  int checks = 0;
  int errors = 0;

  // Model: counter value, rr pointer, and the command in flight as "cycles of work left".
  logic [W-1:0] m_cnt = '0;
  int           m_ptr = 0;
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [1:0]   m_op = 2'b00;
  logic [W-1:0] m_arg = '0;
  int           m_id = 0;
  logic [W-1:0] m_done_val = '0;
  int           m_done_id = 0;
  bit [N-1:0]   fired = '0;
  int           grants[$];
  bit           started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic bit m_idle();
    return (m_left == 0) && !m_done;
  endfunction

  always @(posedge clk) begin
    int g;
    started = 1'b1;
    fired   = '0;
    if (rst) begin
      m_cnt = '0; m_ptr = 0; m_left = 0; m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      case (m_op)
        2'b00:   m_cnt = '0;
        2'b01:   m_cnt = m_arg;
        2'b10:   if (m_arg != 0) m_cnt = m_cnt + 8'd1;
        default: ;
      endcase
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_done_val = m_cnt; m_done_id = m_id;
      end
    end else begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        fired[g] = 1'b1;
        m_op     = req_op[2*g +: 2];
        m_arg    = req_arg[W*g +: W];
        m_id     = g;
        m_left   = (m_op == 2'b10 && m_arg != 0) ? int'(m_arg) : 1;
        m_ptr    = (g + 1) % N;
        grants.push_back(g);
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int g;
    if (started) begin
      exp_ready = '0;
      g = pick(req_valid, m_ptr);
      if (!rst && m_idle() && g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("cnt_value", cnt_value, m_cnt);
      check("busy", busy, !m_idle());
      check("done_valid", done_valid, m_done);
      if (m_done) begin
        check("done_id", done_id, m_done_id);
        check("done_value", done_value, m_done_val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] arg);
    req_op[2*i +: 2]  = op;
    req_arg[W*i +: W] = arg;
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_fire(input int i, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!fired[i] && n < 60);
    check(name, fired[i], 1);
    req_valid[i] = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (req_valid != '0 && n < 80) begin
      tick();
      n++;
      for (int i = 0; i < N; i++) if (fired[i]) req_valid[i] = 1'b0;
    end
    check(name, req_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '1;
    req_op = '1;
    req_arg = '0;
    // Reset held with every requester asking.
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_ready", req_ready, 0);
    end
    check("rst_cnt", cnt_value, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_valid, 0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // LOAD 0xFE then STEP 3 wrapping through zero.
    set_req(1, 2'b01, 8'hFE);
    wait_fire(1, "t2_grant1");
    tick();
    check("t2_cnt", cnt_value, 8'hFE);
    check("t2_done", done_valid, 1);
    check("t2_id", done_id, 1);
    check("t2_val", done_value, 8'hFE);
    tick();
    check("t2_idle", busy, 0);
    set_req(2, 2'b10, 8'd3);
    wait_fire(2, "t2_grant2");
    tick(); check("t2_s1", cnt_value, 8'hFF);
    tick(); check("t2_s2", cnt_value, 8'h00);
    tick(); check("t2_s3", cnt_value, 8'h01);
    check("t2_sdone", done_valid, 1);
    check("t2_sid", done_id, 2);
    tick();

    // Round-robin order from a freshly reset pointer, then wrap.
    rst = 1'b1; tick(); rst = 1'b0;
    grants.delete();
    for (int i = 0; i < N; i++) set_req(i, 2'b11, 8'h00);
    drain("t3_drain_a");
    check("t3_n", grants.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_order", (grants.size() > i) ? grants[i] : -1, i);
    grants.delete();
    set_req(0, 2'b11, 8'h00);
    set_req(3, 2'b11, 8'h00);
    drain("t3_drain_b");
    check("t3_wrap0", (grants.size() > 0) ? grants[0] : -1, 0);
    check("t3_wrap1", (grants.size() > 1) ? grants[1] : -1, 3);

    // STEP 0 completes after one EXEC cycle with the count untouched.
    set_req(3, 2'b01, 8'h33);
    wait_fire(3, "t4_load");
    set_req(3, 2'b10, 8'd0);
    wait_fire(3, "t4_grant");
    check("t4_busy0", busy, 1);
    tick();
    check("t4_done", done_valid, 1);
    check("t4_val", done_value, 8'h33);
    check("t4_busy1", busy, 1);
    tick();
    check("t4_busy2", busy, 0);

    // Reset in the middle of a STEP 10.
    set_req(1, 2'b01, 8'hF0);
    wait_fire(1, "t5_load");
    set_req(1, 2'b10, 8'd10);
    wait_fire(1, "t5_grant");
    for (int c = 0; c < 4; c++) tick();
    check("t5_mid", cnt_value, 8'hF4);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_cnt", cnt_value, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done_valid, 0);
    grants.delete();
    set_req(0, 2'b11, 8'h00);
    set_req(2, 2'b11, 8'h00);
    drain("t5_drain");
    check("t5_ptr", (grants.size() > 0) ? grants[0] : -1, 0);

    // CLEAR while req0 waits: req0 only sees ready once DONE has passed.
    set_req(1, 2'b01, 8'h55);
    wait_fire(1, "t6_load");
    set_req(2, 2'b00, 8'h00);
    wait_fire(2, "t6_clear");
    set_req(0, 2'b11, 8'h00);
    tick();
    check("t6_cnt", cnt_value, 0);
    check("t6_done", done_valid, 1);
    check("t6_noready", req_ready, 0);
    tick();
    check("t6_ready", req_ready, 4'b0001);
    wait_fire(0, "t6_grant0");

    // Random traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 399) == 0) rst = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (fired[i]) begin
          req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          logic [1:0] op;
          op = 2'($urandom_range(0, 3));
          set_req(i, op, (op == 2'b10) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255)));
        end
      end
    end
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 20; c++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
